// File: rtl/ps2_mouse_dev_funcmod_pkg.sv
// Shared state encoding, host command codes and device response bytes
// for the PS/2 mouse device model.
package ps2_mouse_dev_funcmod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_TX_WAIT,
    ST_TX_BIT,
    ST_RX_BIT,
    ST_RX_ACK
  } ps2_state_e;

  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_DISABLE = 8'hF5;
  localparam logic [7:0] CMD_GET_ID  = 8'hF2;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  localparam logic [3:0] LAST_BIT = 4'd10;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_dev_frame_funcmod.sv
// Single-byte PS/2 device cell engine: idle qualification, 11-bit device
// frames with host-inhibit abort, and host-to-device reception with ack.
module ps2_dev_frame_funcmod
  import ps2_mouse_dev_funcmod_pkg::*;
#(
  parameter int T_Q    = 1000,
  parameter int T_IDLE = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_s_i,
  input  logic       dat_s_i,
  input  logic       tx_req_i,
  input  logic [7:0] tx_byte_i,
  output logic       clk_low_o,
  output logic       dat_low_o,
  output logic       tx_done_o,
  output logic       tx_abort_o,
  output logic       rx_start_o,
  output logic       rx_done_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_par_o
);
  localparam int CW     = $clog2(((T_Q > T_IDLE) ? T_Q : T_IDLE) + 1);
  // Our own CLK release needs a few cycles to show through the synchronizer.
  localparam int SETTLE = 3;

  ps2_state_e      state_q, state_d;
  logic [3:0]      bit_q;
  logic [1:0]      quarter_q;
  logic [CW-1:0]   qcnt_q;
  logic [CW-1:0]   idle_q;
  logic [9:0]      rx_sh_q;

  logic            q_end, cell_end, in_cell, inhibit_seen;
  logic [10:0]     tx_frame;

  assign q_end    = (qcnt_q == CW'(T_Q - 1));
  assign cell_end = q_end && (quarter_q == 2'd3);
  assign in_cell  = (state_q == ST_TX_BIT) || (state_q == ST_RX_BIT) || (state_q == ST_RX_ACK);
  assign tx_frame = {1'b1, odd_parity(tx_byte_i), tx_byte_i, 1'b0};
  assign inhibit_seen = (state_q == ST_TX_BIT) && !clk_s_i &&
                        ((quarter_q == 2'd1) || ((quarter_q == 2'd0) && (qcnt_q >= CW'(SETTLE))));
  assign rx_byte_o = rx_sh_q[7:0];
  assign rx_par_o  = rx_sh_q[8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      quarter_q <= '0;
      qcnt_q    <= '0;
      idle_q    <= '0;
      rx_sh_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || !in_cell) begin
        qcnt_q    <= '0;
        quarter_q <= '0;
      end else if (q_end) begin
        qcnt_q    <= '0;
        quarter_q <= quarter_q + 2'd1;
      end else begin
        qcnt_q <= qcnt_q + CW'(1);
      end
      if ((state_d != state_q) && ((state_d == ST_TX_BIT) || (state_d == ST_RX_BIT)))
        bit_q <= '0;
      else if (in_cell && cell_end && (bit_q != LAST_BIT))
        bit_q <= bit_q + 4'd1;
      if ((state_q == ST_TX_WAIT) && clk_s_i && dat_s_i) begin
        if (idle_q != CW'(T_IDLE))
          idle_q <= idle_q + CW'(1);
      end else begin
        idle_q <= '0;
      end
      if ((state_q == ST_RX_BIT) && (quarter_q == 2'd1) && q_end)
        rx_sh_q <= {dat_s_i, rx_sh_q[9:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (!clk_s_i) state_d = ST_INHIBIT;
                  else if (tx_req_i) state_d = ST_TX_WAIT;
      ST_INHIBIT: if (clk_s_i) state_d = dat_s_i ? ST_IDLE : ST_RX_BIT;
      ST_TX_WAIT: if (!clk_s_i) state_d = ST_INHIBIT;
                  else if (!tx_req_i) state_d = ST_IDLE;
                  else if (idle_q == CW'(T_IDLE)) state_d = ST_TX_BIT;
      ST_TX_BIT:  if (inhibit_seen) state_d = ST_INHIBIT;
                  else if (cell_end && (bit_q == LAST_BIT)) state_d = ST_IDLE;
      // A zero stop bit gets no ack cell at all; the byte is dropped.
      ST_RX_BIT:  if (cell_end && (bit_q == LAST_BIT - 4'd1))
                    state_d = rx_sh_q[9] ? ST_RX_ACK : ST_IDLE;
      ST_RX_ACK:  if (cell_end) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clk_low_o  = 1'b0;
    dat_low_o  = 1'b0;
    tx_done_o  = 1'b0;
    tx_abort_o = 1'b0;
    rx_start_o = 1'b0;
    rx_done_o  = 1'b0;
    case (state_q)
      ST_TX_BIT: begin
        clk_low_o  = quarter_q[1];
        dat_low_o  = !tx_frame[bit_q];
        tx_done_o  = cell_end && (bit_q == LAST_BIT) && !inhibit_seen;
        tx_abort_o = inhibit_seen;
      end
      ST_RX_BIT:  clk_low_o = !quarter_q[1];
      ST_RX_ACK: begin
        clk_low_o = !quarter_q[1];
        dat_low_o = 1'b1;
        rx_done_o = cell_end;
      end
      ST_INHIBIT: rx_start_o = clk_s_i && !dat_s_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/ps2_mouse_dev_funcmod.sv
// PS/2 mouse device: line synchronizers, packet/response queue and host
// command decode around the single-byte frame engine.
module ps2_mouse_dev_funcmod
  import ps2_mouse_dev_funcmod_pkg::*;
#(
  parameter int T_Q    = 1000,
  parameter int T_IDLE = 2500
) (
  input  logic        CLOCK,
  input  logic        RST,
  inout  wire         PS2_CLK,
  inout  wire         PS2_DAT,
  input  logic        iTrig,
  input  logic [23:0] iData,
  output logic        oBusy,
  output logic        oEn,
  output logic        oCmdTrig,
  output logic [7:0]  oCmd
);
  logic [1:0]  clk_sync_q, dat_sync_q;
  logic [23:0] pkt_q;
  logic [1:0]  len_q, idx_q;
  logic        en_q, cmd_trig_q;
  logic [7:0]  cmd_q;

  logic        clk_low, dat_low, tx_done, tx_abort, rx_start, rx_done, rx_par, trig_ok;
  logic [7:0]  tx_byte, rx_byte;

  assign PS2_CLK  = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT  = dat_low ? 1'b0 : 1'bz;
  assign oBusy    = (len_q != 2'd0);
  assign oEn      = en_q;
  assign oCmdTrig = cmd_trig_q;
  assign oCmd     = cmd_q;
  assign trig_ok  = iTrig && en_q && !oBusy;
  assign tx_byte  = (idx_q == 2'd0) ? pkt_q[7:0] :
                    (idx_q == 2'd1) ? pkt_q[15:8] : pkt_q[23:16];

  ps2_dev_frame_funcmod #(.T_Q(T_Q), .T_IDLE(T_IDLE)) u_frame (
    .clk        (CLOCK),
    .rst        (RST),
    .clk_s_i    (clk_sync_q[1]),
    .dat_s_i    (dat_sync_q[1]),
    .tx_req_i   (idx_q != len_q),
    .tx_byte_i  (tx_byte),
    .clk_low_o  (clk_low),
    .dat_low_o  (dat_low),
    .tx_done_o  (tx_done),
    .tx_abort_o (tx_abort),
    .rx_start_o (rx_start),
    .rx_done_o  (rx_done),
    .rx_byte_o  (rx_byte),
    .rx_par_o   (rx_par)
  );

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      pkt_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      en_q       <= 1'b0;
      cmd_trig_q <= 1'b0;
      cmd_q      <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      cmd_trig_q <= 1'b0;
      if (rx_done) begin
        // Any response replaces whatever packet was queued.
        idx_q <= 2'd0;
        len_q <= 2'd1;
        pkt_q <= {16'h0000, RSP_ACK};
        if (rx_par != odd_parity(rx_byte)) begin
          pkt_q <= {16'h0000, RSP_RESEND};
        end else begin
          cmd_trig_q <= 1'b1;
          cmd_q      <= rx_byte;
          case (rx_byte)
            CMD_ENABLE:  en_q <= 1'b1;
            CMD_DISABLE: en_q <= 1'b0;
            CMD_GET_ID: begin
              pkt_q <= {8'h00, RSP_ID, RSP_ACK};
              len_q <= 2'd2;
            end
            CMD_RESET: begin
              pkt_q <= {RSP_ID, RSP_BAT, RSP_ACK};
              len_q <= 2'd3;
              en_q  <= 1'b0;
            end
            default: ;
          endcase
        end
      end else if (rx_start) begin
        len_q <= 2'd0;
        idx_q <= 2'd0;
      end else if (tx_abort) begin
        idx_q <= 2'd0;
      end else if (tx_done) begin
        if (idx_q + 2'd1 == len_q) begin
          len_q <= 2'd0;
          idx_q <= 2'd0;
        end else begin
          idx_q <= idx_q + 2'd1;
        end
      end else if (trig_ok) begin
        pkt_q <= iData;
        len_q <= 2'd3;
        idx_q <= 2'd0;
      end
    end
  end

endmodule
